// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - multi-channel programmable clock divider with glitch-free period updates
// Each channel counts 0..P-1; new periods wait in a pending slot until the channel wraps or restart.
module prog_clk_divider #(
    parameter int N_CH       = 4,
    parameter int W          = 30,
    parameter int DEF_PERIOD = 500000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            restart,
    input  logic            wr_en,
    input  logic [2:0]      wr_ch,
    input  logic [W-1:0]    wr_period,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] pend
);

    localparam logic [W-1:0] DEF = W'(DEF_PERIOD);
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TWO = W'(2);

    logic [W-1:0]    cnt_q [N_CH];
    logic [W-1:0]    cnt_d [N_CH];
    logic [W-1:0]    per_q [N_CH];
    logic [W-1:0]    per_d [N_CH];
    logic [W-1:0]    nxt_q [N_CH];
    logic [W-1:0]    nxt_d [N_CH];
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_d;

    logic            wr_ok;
    logic [N_CH-1:0] wr_hit;
    logic [N_CH-1:0] at_end;

    always_comb begin
        wr_ok = wr_en && ({1'b0, wr_ch} < 4'(N_CH)) && (wr_period >= TWO);
    end

    always_comb begin
        wr_hit = '0;
        at_end = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_ok && (wr_ch == 3'(i));
            at_end[i] = (cnt_q[i] == per_q[i] - ONE);
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            per_d[i]  = per_q[i];
            nxt_d[i]  = nxt_q[i];
            pend_d[i] = pend_q[i];
            if (restart) begin
                // A write coinciding with restart bypasses the pending slot entirely.
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
                if (wr_hit[i]) begin
                    per_d[i] = wr_period;
                    nxt_d[i] = wr_period;
                end else if (pend_q[i]) begin
                    per_d[i] = nxt_q[i];
                end
            end else begin
                if (en) begin
                    cnt_d[i] = at_end[i] ? '0 : cnt_q[i] + ONE;
                end
                // A write landing in the wrap cycle defers to the following wrap.
                if (wr_hit[i]) begin
                    nxt_d[i]  = wr_period;
                    pend_d[i] = 1'b1;
                end else if (en && at_end[i] && pend_q[i]) begin
                    per_d[i]  = nxt_q[i];
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                per_q[i] <= DEF;
                nxt_q[i] <= DEF;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                per_q[i] <= per_d[i];
                nxt_q[i] <= nxt_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // en only qualifies tick; the terminal-count decode itself comes from registers.
    always_comb begin
        q    = '0;
        tick = '0;
        for (int i = 0; i < N_CH; i++) begin
            q[i]    = (cnt_q[i] >= (per_q[i] >> 1));
            tick[i] = en && at_end[i];
        end
    end

    assign pend = pend_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb/tb_prog_clk_divider.sv - self-checking bench for prog_clk_divider
module tb_prog_clk_divider;

    localparam int NC  = 4;
    localparam int WW  = 30;
    localparam int DEF = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          restart = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [WW-1:0] wr_period = '0;
    logic [NC-1:0] q, tick, pend;

    prog_clk_divider #(.N_CH(NC), .W(WW), .DEF_PERIOD(DEF)) dut (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period),
        .q(q), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_cnt [NC];
    int m_p   [NC];
    int m_n   [NC];
    bit m_pend[NC];

    logic [NC-1:0] sq, st, sp;

    typedef struct {
        bit            en;
        logic [NC-1:0] q;
        logic [NC-1:0] tick;
        logic [NC-1:0] pend;
    } vec_t;
    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_p[i] = DEF; m_n[i] = DEF; m_pend[i] = 0;
        end
    endtask

    task automatic model_clock(input bit e, input bit r, input bit we, input int ch, input int per);
        bit acc;
        bit wrap;
        acc = we && ch < NC && per >= 2;
        for (int i = 0; i < NC; i++) begin
            if (r) begin
                m_cnt[i] = 0;
                if (acc && ch == i) begin m_p[i] = per; m_n[i] = per; end
                else if (m_pend[i]) m_p[i] = m_n[i];
                m_pend[i] = 0;
            end else begin
                wrap = e && (m_cnt[i] == m_p[i] - 1);
                if (e) m_cnt[i] = (m_cnt[i] + 1) % m_p[i];
                if (acc && ch == i) begin m_n[i] = per; m_pend[i] = 1; end
                else if (wrap && m_pend[i]) begin m_p[i] = m_n[i]; m_pend[i] = 0; end
            end
        end
    endtask

    // Drive on the falling edge, sample 1ns later, then advance the model on the rising edge.
    task automatic step(input bit e, input bit r, input bit we, input int ch, input int per);
        logic [NC-1:0] eq, et, ep;
        @(negedge clk);
        en = e; restart = r; wr_en = we; wr_ch = 3'(ch); wr_period = WW'(per);
        #1;
        for (int i = 0; i < NC; i++) begin
            eq[i] = (m_cnt[i] >= m_p[i] / 2);
            et[i] = e && (m_cnt[i] == m_p[i] - 1);
            ep[i] = m_pend[i];
        end
        sq = q; st = tick; sp = pend;
        chk("model_q", 32'(q), 32'(eq));
        chk("model_tick", 32'(tick), 32'(et));
        chk("model_pend", 32'(pend), 32'(ep));
        @(posedge clk);
        model_clock(e, r, we, ch, per);
    endtask

    initial begin
        for (int k = 0; k < 24; k++) begin
            tbl[k].en   = 1'b1;
            tbl[k].q    = (k % 8 >= 4) ? 4'hF : 4'h0;
            tbl[k].tick = (k % 8 == 7) ? 4'hF : 4'h0;
            tbl[k].pend = 4'h0;
        end

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", 32'(q), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_pend", 32'(pend), 0);
        @(negedge clk);
        reset = 1'b0;

        // Default period 8 on every channel.
        for (int k = 0; k < 24; k++) begin
            step(tbl[k].en, 0, 0, 0, 0);
            chk("tbl_q", 32'(sq), 32'(tbl[k].q));
            chk("tbl_tick", 32'(st), 32'(tbl[k].tick));
            chk("tbl_pend", 32'(sp), 32'(tbl[k].pend));
        end

        // Mid-period write of period 5 to channel 1.
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 5);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0);
            chk("ch1_pend_wait", 32'(sp[1]), 1);
        end
        begin
            bit q1 [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
            bit t1 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            for (int k = 0; k < 10; k++) begin
                step(1, 0, 0, 0, 0);
                chk("ch1_q", 32'(sq[1]), 32'(q1[k]));
                chk("ch1_tick", 32'(st[1]), 32'(t1[k]));
                chk("ch1_pend_clr", 32'(sp[1]), 0);
                chk("ch0_q", 32'(sq[0]), (k % 8 >= 4) ? 1 : 0);
            end
        end

        // Invalid writes are dropped.
        step(0, 0, 1, 2, 1);
        step(0, 0, 1, 7, 4);
        step(0, 0, 0, 0, 0);
        chk("bad_wr_pend", 32'(sp), 0);
        repeat (8) step(1, 0, 0, 0, 0);

        // Write coincident with restart takes effect immediately.
        step(0, 1, 1, 3, 3);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 0, 0);
            if (k == 0) begin
                chk("rst_q_zero", 32'(sq), 0);
                chk("rst_pend_zero", 32'(sp), 0);
            end
            chk("ch3_tick", 32'(st[3]), (k % 3 == 2) ? 1 : 0);
        end

        // Hold at cnt 5 with en low, then resume.
        step(0, 1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0);
            chk("hold_q0", 32'(sq[0]), 1);
            chk("hold_tick", 32'(st), 0);
        end
        step(1, 0, 0, 0, 0);
        chk("resume_q0_c5", 32'(sq[0]), 1);
        chk("resume_tick0_c5", 32'(st[0]), 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("resume_tick0_c7", 32'(st[0]), 1);

        // Asynchronous reset with a pending period on channel 0.
        step(0, 0, 1, 0, 6);
        step(1, 0, 0, 0, 0);
        chk("pend0_set", 32'(sp[0]), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_q", 32'(q), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_pend", 32'(pend), 0);
        en = 1'b0; restart = 1'b0; wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1, 0, 0, 0, 0);
            chk("post_rst_tick0", 32'(st[0]), (k % 8 == 7) ? 1 : 0);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 13)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
